// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer fill/copy DMA controller.
// Holds the command op encoding, the engine state enum and default widths.
package fb_pkg;

    localparam int FB_ADDR_W = 15;
    localparam int FB_DATA_W = 16;

    localparam logic FB_OP_FILL = 1'b0;
    localparam logic FB_OP_COPY = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_CP_RD,
        ST_CP_CAP,
        ST_CP_WR,
        ST_DONE
    } fb_state_e;

endpackage

// File: rtl/fb_dma_ctrl.sv
// Framebuffer DMA engine: FILL / COPY on port A, CPU has fixed priority on the port.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a command, cmd_ready=1
// ST_FILL   | one color write per granted cycle
// ST_CP_RD  | present source address for a read
// ST_CP_CAP | capture read data into the hold register (port not needed)
// ST_CP_WR  | write hold register to destination, advance pointers
// ST_DONE   | one-cycle completion pulse
module fb_dma_ctrl
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] cmd_color,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              op_q, op_d;

    logic              grant;
    logic              last;
    logic [ADDR_W:0]   len_dec;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_we;
    logic [DATA_W-1:0] eng_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            color_q <= '0;
            hold_q  <= '0;
            op_q    <= FB_OP_FILL;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            color_q <= color_d;
            hold_q  <= hold_d;
            op_q    <= op_d;
        end
    end

    assign grant   = ~cpu_req;
    // Saturating decrement keeps len from wrapping even if reached at zero.
    assign last    = (len_q <= (ADDR_W+1)'(1));
    assign len_dec = (len_q == '0) ? '0 : len_q - (ADDR_W+1)'(1);

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        color_d   = color_q;
        hold_d    = hold_q;
        op_d      = op_q;
        eng_addr  = dst_q;
        eng_we    = 1'b0;
        eng_wdata = (op_q == FB_OP_COPY) ? hold_q : color_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    len_d   = cmd_len;
                    color_d = cmd_color;
                    op_d    = cmd_op;
                    if (cmd_len == '0)
                        state_d = ST_DONE;
                    else if (cmd_op == FB_OP_COPY)
                        state_d = ST_CP_RD;
                    else
                        state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                eng_we = 1'b1;
                if (grant) begin
                    dst_d   = dst_q + ADDR_W'(1);
                    len_d   = len_dec;
                    state_d = last ? ST_DONE : ST_FILL;
                end
            end
            ST_CP_RD: begin
                eng_addr = src_q;
                if (grant)
                    state_d = ST_CP_CAP;
            end
            ST_CP_CAP: begin
                // Read data belongs to the CP_RD address even if the CPU owns the port now.
                hold_d  = mem_rdata;
                state_d = ST_CP_WR;
            end
            ST_CP_WR: begin
                eng_we = 1'b1;
                if (grant) begin
                    src_d   = src_q + ADDR_W'(1);
                    dst_d   = dst_q + ADDR_W'(1);
                    len_d   = len_dec;
                    state_d = last ? ST_DONE : ST_CP_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        if (cpu_req) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else begin
            mem_addr  = eng_addr;
            mem_we    = eng_we & ~reset;
            mem_wdata = eng_wdata;
        end
    end

    assign cmd_ready = reset | (state_q == ST_IDLE);
    assign busy      = ~reset & (state_q != ST_IDLE);
    assign done      = ~reset & (state_q == ST_DONE);

endmodule

// File: tb/tb_fb_dma_ctrl.sv
// Self-checking bench for fb_dma_ctrl: directed command table, reset abort,
// and random commands compared against an array-based memory model.
module tb_fb_dma_ctrl;
    import fb_pkg::*;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [AW-1:0] cmd_src = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [AW:0]   cmd_len = '0;
    logic [DW-1:0] cmd_color = '0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          done;

    int n_chk = 0;
    int n_pass = 0;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] ref_mem [N];
    logic          loaded = 1'b0;

    typedef struct {
        logic          op;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW:0]   len;
        logic [DW-1:0] color;
        int            mode;     // 0 no CPU, 1 random CPU, 2 CPU on cycles s_lo..s_hi
        int            s_lo;
        int            s_hi;
        int            exp_lat;  // cycles from acceptance to done, -1 = not checked
        string         nm;
    } cmd_vec_t;

    fb_dma_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_color(cmd_color),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'((i * 40503) ^ 32'h5a5a);
    endfunction

    // Port-A RAM: registered read, write on the same edge.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < N; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int mem_diff();
        int bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
        return bad;
    endfunction

    task automatic set_cpu(input logic req);
        cpu_req   = req;
        cpu_we    = 1'($urandom % 2);
        cpu_addr  = AW'(32'h6000 + ($urandom % 4096));
        cpu_wdata = DW'($urandom);
    endtask

    function automatic cmd_vec_t mk(input logic op, input int src, input int dst, input int len,
                                    input int color, input int mode, input int s_lo,
                                    input int s_hi, input int exp_lat, input string nm);
        cmd_vec_t r;
        r.op = op; r.src = AW'(src); r.dst = AW'(dst); r.len = (AW+1)'(len);
        r.color = DW'(color); r.mode = mode; r.s_lo = s_lo; r.s_hi = s_hi;
        r.exp_lat = exp_lat; r.nm = nm;
        return r;
    endfunction

    task automatic run_cmd(input cmd_vec_t v);
        logic [AW+DW-1:0] exp_q[$];
        logic [AW+DW-1:0] obs_q[$];
        logic [AW-1:0]    a, s;
        logic [DW-1:0]    d;
        int k, lat, done_cnt, busy_bad, limit, seq_bad;

        // Expected effect: strictly ascending word-by-word copy/fill with address wrap.
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.dst + AW'(i);
            s = v.src + AW'(i);
            d = (v.op == FB_OP_FILL) ? v.color : ref_mem[s];
            ref_mem[a] = d;
            exp_q.push_back({a, d});
        end

        @(negedge clk);
        set_cpu(1'b0);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_src = v.src; cmd_dst = v.dst;
        cmd_len = v.len; cmd_color = v.color;
        #1;
        chk({v.nm, "/ready"}, 32'(cmd_ready), 32'd1);
        chk({v.nm, "/idle_busy"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;

        k = 0; lat = -1; done_cnt = 0; busy_bad = 0;
        limit = 12 * int'(v.len) + 20;
        while (k < limit) begin
            k++;
            @(negedge clk);
            if (lat >= 0) set_cpu(1'b0);
            else if (v.mode == 1) set_cpu(($urandom % 4) == 0);
            else if (v.mode == 2) set_cpu(k >= v.s_lo && k <= v.s_hi);
            else set_cpu(1'b0);
            #1;
            if (cpu_req) begin
                chk({v.nm, "/cpu_mux"}, {mem_addr, mem_we, mem_wdata}, {cpu_addr, cpu_we, cpu_wdata});
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            end else if (mem_we) begin
                obs_q.push_back({mem_addr, mem_wdata});
            end
            if (lat < 0 && !busy) busy_bad++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = k;
            end
            if (lat >= 0 && k >= lat + 3) break;
        end

        chk({v.nm, "/done_seen"}, 32'(lat >= 0), 32'd1);
        if (v.exp_lat >= 0) chk({v.nm, "/latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.nm, "/done_pulses"}, 32'(done_cnt), 32'd1);
        chk({v.nm, "/busy_active"}, 32'(busy_bad), 32'd0);
        chk({v.nm, "/post_idle"}, {30'd0, busy, cmd_ready}, 32'd1);
        chk({v.nm, "/n_writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        seq_bad = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) seq_bad++;
        chk({v.nm, "/write_seq"}, 32'(seq_bad), 32'd0);
        chk({v.nm, "/mem"}, 32'(mem_diff()), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_vec_t tbl [9];
        cmd_vec_t rv;
        int wcnt, dcnt;
        int len, lat;
        logic op;
        logic [AW-1:0] src;

        for (int i = 0; i < N; i++) ref_mem[i] = init_val(i);

        tbl[0] = mk(FB_OP_FILL, 'h0100, 'h0100, 4, 'hF800, 0, 0, 0, 5,  "fill4");
        tbl[1] = mk(FB_OP_COPY, 'h0000, 'h1000, 2, 0,      0, 0, 0, 7,  "copy2");
        tbl[2] = mk(FB_OP_FILL, 'h0000, 'h0200, 3, 'h07E0, 2, 2, 3, 6,  "fill_cpu");
        tbl[3] = mk(FB_OP_COPY, 'h0040, 'h0800, 1, 0,      2, 2, 2, 4,  "copy_cap_cpu");
        tbl[4] = mk(FB_OP_FILL, 'h0000, 'h0300, 0, 'h1111, 0, 0, 0, 1,  "len0_fill");
        tbl[5] = mk(FB_OP_COPY, 'h0010, 'h0400, 0, 0,      0, 0, 0, 1,  "len0_copy");
        tbl[6] = mk(FB_OP_FILL, 'h0000, 'h7FFF, 2, 'hABCD, 0, 0, 0, 3,  "fill_wrap");
        tbl[7] = mk(FB_OP_COPY, 'h7FFE, 'h0010, 3, 0,      0, 0, 0, 10, "copy_wrap");
        tbl[8] = mk(FB_OP_COPY, 'h0300, 'h0301, 4, 0,      0, 0, 0, 13, "copy_overlap");

        // Reset state, including the CPU path through the port mux.
        repeat (3) @(negedge clk);
        #1;
        chk("rst/ready", 32'(cmd_ready), 32'd1);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h6123; cpu_wdata = 16'hBEEF;
        #1;
        chk("rst/cpu_we", {mem_addr, mem_we, mem_wdata}, {15'h6123, 1'b1, 16'hBEEF});
        ref_mem[15'h6123] = 16'hBEEF;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_cmd(tbl[i]);

        // Reset in the middle of a FILL: two words land, then nothing more.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = FB_OP_FILL; cmd_dst = 15'h2000;
        cmd_len = 16'd10; cmd_color = 16'h1234;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            #1;
            chk("rstmid/write", {mem_addr, mem_we, mem_wdata},
                {AW'(15'h2000 + k - 1), 1'b1, 16'h1234});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstmid/gated", {29'd0, mem_we, busy, cmd_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid/idle", {29'd0, done, busy, cmd_ready}, 32'd1);
        wcnt = 0; dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (mem_we) wcnt++;
            if (done) dcnt++;
        end
        chk("rstmid/no_writes", 32'(wcnt), 32'd0);
        chk("rstmid/no_done", 32'(dcnt), 32'd0);
        ref_mem[15'h2000] = 16'h1234;
        ref_mem[15'h2001] = 16'h1234;
        chk("rstmid/mem", 32'(mem_diff()), 32'd0);

        // Random commands; latency only checked when the CPU stays off the port.
        for (int i = 0; i < 24; i++) begin
            op  = 1'($urandom % 2);
            len = (($urandom % 8) == 0) ? 0 : int'($urandom % 48) + 1;
            src = AW'($urandom % 32'h4000);
            rv.op = op; rv.src = src;
            rv.dst = (($urandom % 3) == 0) ? AW'(src + AW'($urandom % 9))
                                            : AW'($urandom % 32'h4000);
            rv.len = (AW+1)'(len);
            rv.color = DW'($urandom);
            rv.mode = i % 2;
            rv.s_lo = 0; rv.s_hi = 0;
            lat = (len == 0) ? 1 : ((op == FB_OP_COPY) ? 3 * len + 1 : len + 1);
            rv.exp_lat = (rv.mode == 0) ? lat : -1;
            rv.nm = $sformatf("rand%0d", i);
            run_cmd(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
